// File: rtl/ifu_prefetch_if.sv
// Bundled instruction-memory and decode-side signals of the fetch front end.
// The master modport is the prefetcher itself; slave is its environment.
interface ifu_prefetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_we;
   logic        flush;
   logic [31:0] flush_target;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_out, pc_out, pc_plus4_out,
      input  imem_ready, imem_rvalid, imem_rdata, if_we, flush, flush_target
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_out, pc_out, pc_plus4_out,
      output imem_ready, imem_rvalid, imem_rdata, if_we, flush, flush_target
   );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: credit-limited in-order requests to a variable-latency
// memory, a DEPTH-entry queue of {pc, inst}, and flush-time discard of stale replies.
module ifu_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input logic            clk,
   input logic            rst,
   ifu_prefetch_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;
   localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t        q [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, outstanding, discard, outstanding_nxt;
   logic [31:0]   fetch_pc, resp_pc;
   logic          credit_ok, accept, drop, push, pop, head_valid, inst_valid;
   logic          unused_tgt_lsb;

   assign unused_tgt_lsb = ^bus.flush_target[1:0];

   // Queued plus in-flight words never exceed the queue size, so a push always fits.
   assign credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_S;
   assign head_valid = (count != '0);
   assign drop       = (discard != '0);

   assign bus.imem_req  = !rst && !bus.flush && credit_ok;
   assign bus.imem_addr = fetch_pc;
   assign accept        = bus.imem_req && bus.imem_ready;
   assign push          = bus.imem_rvalid && !drop && !bus.flush;
   assign pop           = head_valid && bus.if_we && !bus.flush;

   assign inst_valid       = !rst && head_valid;
   assign bus.inst_valid   = inst_valid;
   assign bus.inst_out     = inst_valid ? q[rd_ptr].inst : NOP;
   assign bus.pc_out       = inst_valid ? q[rd_ptr].pc : 32'd0;
   assign bus.pc_plus4_out = bus.pc_out + 32'd4;

   always_comb begin
      outstanding_nxt = outstanding;
      if (accept && !bus.imem_rvalid)
         outstanding_nxt = outstanding + CW'(1);
      else if (!accept && bus.imem_rvalid)
         outstanding_nxt = outstanding - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push && !rst)
         q[wr_ptr] <= '{pc: resp_pc, inst: bus.imem_rdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (bus.flush) begin
         // Everything still in flight after this edge belongs to the old stream.
         fetch_pc    <= {bus.flush_target[31:2], 2'b00};
         resp_pc     <= {bus.flush_target[31:2], 2'b00};
         rd_ptr      <= wr_ptr;
         count       <= '0;
         outstanding <= outstanding_nxt;
         discard     <= outstanding_nxt;
      end else begin
         outstanding <= outstanding_nxt;
         if (accept)
            fetch_pc <= fetch_pc + 32'd4;
         if (bus.imem_rvalid && drop)
            discard <= discard - CW'(1);
         if (push) begin
            wr_ptr  <= wr_ptr + AW'(1);
            resp_pc <= resp_pc + 32'd4;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule
